scu_dsp_ram_host_port: RTL and testbench

- Host-side initiator for one SCU DSP data RAM bank group. It turns CPU register accesses into read and write cycles on a single RAM port.
- It holds an 8-bit address register: 2 bank bits plus a 6-bit word index. Every data-port access auto-increments the index.
- It blocks data access while the DSP program is running.
- It drives the port of the DSP dual-port data RAM that the DSP core does not use.

---
 rtl/scu_dsp_ram_host_port.sv | 88 ++++++++
 tb/tb_scu_dsp_ram_host_port.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scu_dsp_ram_host_port.sv
// scu_dsp_ram_host_port: host register port into one SCU DSP data RAM bank group
module scu_dsp_ram_host_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] RUN_FILL = '1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic              SEL,
    input  logic [DATA_W-1:0] WDATA,
    output logic              ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    input  logic              DSP_RUN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DATA,
    output logic              RAM_WREN,
    input  logic [DATA_W-1:0] RAM_Q
);
    localparam int IW = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, AWR, DWR, DRD, DONE} state_t;

    state_t state, state_nxt;
    logic [ADDR_W-1:0] ar;
    logic we_q, run_q;
    logic [ADDR_W-1:0] ar_inc;

    // bank bits are held; only the word index wraps
    assign ar_inc = {ar[ADDR_W-1 -: 2], ar[IW-1:0] + 1'b1};

    always_comb begin
        state_nxt = state;
        ACK = 1'b0;
        BUSY = 1'b1;
        RAM_WREN = 1'b0;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (REQ) state_nxt = !SEL ? AWR : WE ? DWR : DRD;
            end
            AWR, DRD: state_nxt = DONE;
            DWR: begin
                state_nxt = DONE;
                RAM_WREN = !run_q;
            end
            default: begin
                state_nxt = IDLE;
                ACK = 1'b1;
            end
        endcase
    end

    assign RAM_ADDR = ar;

    // RAM_DATA doubles as the latched host write data for every access type
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ar <= '0;
            RAM_DATA <= '0;
            RDATA <= '0;
            we_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && REQ) begin
                RAM_DATA <= WDATA;
                we_q <= WE;
                run_q <= DSP_RUN;
            end
            case (state)
                AWR: begin
                    if (we_q) ar <= RAM_DATA[ADDR_W-1:0];
                    else RDATA <= DATA_W'(ar);
                end
                DWR: if (!run_q) ar <= ar_inc;
                DRD: begin
                    RDATA <= run_q ? RUN_FILL : RAM_Q;
                    if (!run_q) ar <= ar_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_scu_dsp_ram_host_port.sv
// tb_scu_dsp_ram_host_port: directed scoreboard bench for the DSP RAM host port
module tb_scu_dsp_ram_host_port;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic        SEL = 1'b0;
    logic [31:0] WDATA = '0;
    logic        DSP_RUN = 1'b0;
    logic [31:0] RAM_Q;
    logic        ACK, BUSY, RAM_WREN;
    logic [31:0] RDATA, RAM_DATA;
    logic [7:0]  RAM_ADDR;

    logic [31:0] mem [256];
    logic [39:0] wr_log [$];
    logic [31:0] sb [$];
    int vec = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    scu_dsp_ram_host_port dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .SEL(SEL), .WDATA(WDATA),
        .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .DSP_RUN(DSP_RUN),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
    );

    // synchronous RAM model: data valid one cycle after the address
    always @(posedge CLK) begin
        RAM_Q <= mem[RAM_ADDR];
        if (RAM_WREN) begin
            mem[RAM_ADDR] <= RAM_DATA;
            wr_log.push_back({RAM_ADDR, RAM_DATA});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one host access; inputs are scrambled after the accept edge to prove they were latched
    task automatic access(input string tag, input logic sel, input logic we, input logic [31:0] wd,
                          input logic run, input logic [31:0] exp_rd, input logic chk_rd);
        int n;
        @(negedge CLK);
        REQ = 1'b1; SEL = sel; WE = we; WDATA = wd; DSP_RUN = run;
        if (chk_rd) sb.push_back(exp_rd);
        @(posedge CLK);
        #1 REQ = 1'b0; SEL = ~sel; WE = ~we; WDATA = ~wd; DSP_RUN = ~run;
        n = 0;
        while (!ACK && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ack_lat"}, 64'(n), 64'd2);
        chk({tag, "_busy"}, 64'(BUSY), 64'd1);
        if (chk_rd && sb.size() > 0) chk({tag, "_rdata"}, 64'(RDATA), 64'(sb.pop_front()));
        @(negedge CLK);
        chk({tag, "_ack_pulse"}, 64'(ACK), 64'd0);
        DSP_RUN = 1'b0;
    endtask

    initial begin
        int a0, a1;
        #12;
        chk("rst_ack", 64'(ACK), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_wren", 64'(RAM_WREN), 64'd0);
        chk("rst_addr", 64'(RAM_ADDR), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_ramdata", 64'(RAM_DATA), 64'd0);
        @(negedge CLK) RST_N = 1'b1;

        access("ar_rd0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("no_wr_t1", 64'(wr_log.size()), 64'd0);

        access("ar_wr40", 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        chk("addr40", 64'(RAM_ADDR), 64'h40);
        access("dwr1", 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0);
        access("dwr2", 1'b1, 1'b1, 32'h22222222, 1'b0, 32'h0, 1'b0);
        chk("wr_cnt2", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() >= 2) begin
            chk("wr_40", 64'(wr_log.pop_front()), 64'h40_11111111);
            chk("wr_41", 64'(wr_log.pop_front()), 64'h41_22222222);
        end
        chk("addr42", 64'(RAM_ADDR), 64'h42);
        access("ar_rd42", 1'b0, 1'b0, 32'h0, 1'b0, 32'h42, 1'b1);

        access("ar_wr7f", 1'b0, 1'b1, 32'h7F, 1'b0, 32'h0, 1'b0);
        access("dwr7f", 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        chk("wrap_wr", 64'(RAM_ADDR), 64'h40);
        void'(wr_log.pop_front());
        access("ar_wr7f_b", 1'b0, 1'b1, 32'h7F, 1'b0, 32'h0, 1'b0);
        access("drd7f", 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        access("ar_rd_wrap", 1'b0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b1);

        access("ar_wr05", 1'b0, 1'b1, 32'h05, 1'b0, 32'h0, 1'b0);
        access("drd_run", 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1);
        chk("run_rd_addr", 64'(RAM_ADDR), 64'h05);
        access("dwr_run", 1'b1, 1'b1, 32'h12345678, 1'b1, 32'h0, 1'b0);
        chk("run_wr_addr", 64'(RAM_ADDR), 64'h05);
        chk("run_no_wr", 64'(wr_log.size()), 64'd0);

        // REQ held through DONE: next accept only from IDLE
        a0 = -1; a1 = -1;
        @(negedge CLK);
        REQ = 1'b1; SEL = 1'b0; WE = 1'b0;
        for (int c = 1; c <= 12 && a1 < 0; c++) begin
            @(negedge CLK);
            if (ACK) begin
                if (a0 < 0) a0 = c;
                else a1 = c;
            end
        end
        REQ = 1'b0;
        chk("held_ack0", 64'(a0), 64'd2);
        chk("held_ack1", 64'(a1), 64'd5);
        chk("held_rdata", 64'(RDATA), 64'h05);
        @(negedge CLK);
        @(negedge CLK);

        // reset in the middle of a data write
        REQ = 1'b1; SEL = 1'b1; WE = 1'b1; WDATA = 32'hAAAA5555; DSP_RUN = 1'b0;
        @(posedge CLK);
        #1 REQ = 1'b0;
        chk("dwr_active", 64'(RAM_WREN), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_wren", 64'(RAM_WREN), 64'd0);
        chk("arst_addr", 64'(RAM_ADDR), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        @(negedge CLK);
        chk("arst_ack_a", 64'(ACK), 64'd0);
        @(negedge CLK);
        chk("arst_ack_b", 64'(ACK), 64'd0);
        chk("arst_no_wr", 64'(wr_log.size()), 64'd0);
        RST_N = 1'b1;

        access("post_dwr", 1'b1, 1'b1, 32'h600DF00D, 1'b0, 32'h0, 1'b0);
        chk("post_wr_cnt", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() >= 1) chk("post_wr", 64'(wr_log.pop_front()), 64'h00_600DF00D);
        access("post_ar_rd", 1'b0, 1'b0, 32'h0, 1'b0, 32'h01, 1'b1);
        access("post_ar_wr", 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
        access("post_drd", 1'b1, 1'b0, 32'h0, 1'b0, 32'h600DF00D, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
